pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard/stall controller that sequences the IF/ID pipeline register and the PC of the 5-stage MIPS datapath.
- Detects load-use hazards between ID and EX.
- Tracks the multi-cycle multiply/divide unit and stalls HI/LO consumers.
- Flushes IF/ID on a taken branch.
- Drives PC write-enable, IF/ID write-enable and flush, and the ID/EX bubble select.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MD_LATENCY, 4, cycles the mult/div unit stays busy after issue; legal range 1..15.

Ports:
Clk  input  1  pipeline clock; all state updates on posedge.
Reset  input  1  asynchronous, active-high reset.
IFID_Rs  input  5  rs field of the instruction in ID.
IFID_Rt  input  5  rt field of the instruction in ID.
IFID_UsesRt  input  1  ID instruction reads rt as a source.
IFID_IsHiLoRead  input  1  ID instruction is mfhi/mflo.
MDStart  input  1  ID instruction is mult/multu/div/divu.
IDEX_MemRead  input  1  EX-stage instruction is a load.
IDEX_Rt  input  5  destination rt of the EX-stage load.
BranchTaken  input  1  branch/jump in ID resolved taken this cycle.
PCWrite  output  1  PC load enable.
IFIDWrite  output  1  IF/ID register load enable.
IFIDFlush  output  1  IF/ID register clear (insert nop).
IDEXBubble  output  1  zero the control fields entering ID/EX.
MDBusy  output  1  mult/div unit occupied.
StallCount  output  8  saturating count of stall cycles since reset.

Behaviour:
- State: MDCnt (4 bits) and StallCount (8 bits). FSM view: RUN when MDCnt==0, MD_WAIT when MDCnt!=0.
- Reset asserted (async, immediate):
  - MDCnt=0, StallCount=0, MDBusy=0.
  - PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, so the pipeline is frozen and cleared.
  - Normal operation resumes on the first posedge after deassertion.
- Combinational, zero latency, outside reset:
  - LU = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & (IDEX_Rt==IFID_Rt))).
  - MDH = MDBusy & (IFID_IsHiLoRead | MDStart).
  - Stall = LU | MDH.
  - PCWrite = IFIDWrite = ~Stall; IDEXBubble = Stall.
  - IFIDFlush = BranchTaken & ~Stall. A stalled branch is ignored and re-evaluated next cycle with fresh operands.
  - MDBusy = (MDCnt!=0).
- Sequential (posedge Clk):
  - MDStart & ~Stall: MDCnt <= MD_LATENCY (issue accepted; RUN -> MD_WAIT).
  - Else if MDCnt!=0: MDCnt <= MDCnt-1. MD_WAIT -> RUN when it reaches 0.
  - Stall & StallCount!=255: StallCount <= StallCount+1. Saturates at 255, never wraps.
- Boundaries:
  - Back-to-back mult/div: second MDStart stalls while MDBusy=1. It is accepted on the first cycle with MDCnt==0 and reloads MD_LATENCY.
  - MD_LATENCY=1: MDBusy high for exactly one cycle after issue.
  - LU and MDH together: single stall cycle; StallCount increments by 1.
  - Reset during MD_WAIT: MDCnt cleared; MDBusy=0 immediately.
  - Rt==0 load never stalls.

Decomposition:
- Shared package: MIPS register-index width (5), opcode/funct constants for mult/div/mfhi/mflo, and the STALLCNT_MAX=255 constant.
- One natural sub-module: md_busy_tracker, containing MDCnt, the load/decrement logic and MDBusy.
- Hazard equations and StallCount stay in the top.

Test Plan:
- Reset then idle:
  - During Reset=1: PCWrite=0, IFIDFlush=1, IDEXBubble=1.
  - After release with no hazards: PCWrite=1, IFIDWrite=1, StallCount=0.
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle -> PCWrite=0, IDEXBubble=1 that cycle; StallCount=1. Same with IDEX_Rt=0 -> no stall.
- Mult then mfhi, MD_LATENCY=4:
  - MDStart at cycle 0 -> MDBusy=1 for cycles 1-4.
  - IFID_IsHiLoRead held from cycle 1 -> stall cycles 1-4, released cycle 5; StallCount=4.
- Branch: BranchTaken=1 with no hazard -> IFIDFlush=1, PCWrite=1 for one cycle. BranchTaken=1 with LU=1 -> IFIDFlush=0, stall only.
- Saturation: hold a load-use hazard for 300 cycles -> StallCount reads 255 and stays 255.
- Mid-operation reset: assert Reset at cycle 2 of MD_WAIT -> MDBusy=0 asynchronously; after release, mfhi does not stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the IF/ID hazard controller: register-index width,
// mult/div/HI-LO encodings, counter widths and the load-use detector.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned MDCNT_W    = 4;
    localparam int unsigned STALLCNT_W = 8;
    localparam logic [STALLCNT_W-1:0] STALLCNT_MAX = 8'd255;

    // SPECIAL-opcode funct codes for the HI/LO producers and consumers
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic                 uses_rt;
    } id_operands_t;

    // Load in EX writes a register the ID instruction is about to read; $zero never counts
    function automatic logic load_use(input logic                 mem_read,
                                      input logic [REG_IDX_W-1:0] ex_rt,
                                      input id_operands_t         ops);
        return mem_read && (ex_rt != '0) &&
               ((ex_rt == ops.rs) || (ops.uses_rt && (ex_rt == ops.rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit: loads MD_LATENCY on an
// accepted issue and counts down to idle.
module md_busy_tracker
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic MDAccept,
    output logic MDBusy
);

    localparam logic [MDCNT_W-1:0] MD_LOAD = MDCNT_W'(MD_LATENCY);

    logic [MDCNT_W-1:0] md_cnt_q;
    logic [MDCNT_W-1:0] md_cnt_d;
    md_state_e          md_state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // A new issue always wins over the countdown; it is only accepted when the unit is free
    always_comb begin
        md_cnt_d = md_cnt_q;
        md_state = (md_cnt_q != '0) ? MD_WAIT : RUN;
        if (MDAccept) begin
            md_cnt_d = MD_LOAD;
        end else if (md_state == MD_WAIT) begin
            md_cnt_d = md_cnt_q - MDCNT_W'(1);
        end
    end

    assign MDBusy = (md_state == MD_WAIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the IF/ID register and PC: load-use and HI/LO
// interlocks, branch flush, bubble select and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [REG_IDX_W-1:0]  IFID_Rs,
    input  logic [REG_IDX_W-1:0]  IFID_Rt,
    input  logic                  IFID_UsesRt,
    input  logic                  IFID_IsHiLoRead,
    input  logic                  MDStart,
    input  logic                  IDEX_MemRead,
    input  logic [REG_IDX_W-1:0]  IDEX_Rt,
    input  logic                  BranchTaken,
    output logic                  PCWrite,
    output logic                  IFIDWrite,
    output logic                  IFIDFlush,
    output logic                  IDEXBubble,
    output logic                  MDBusy,
    output logic [STALLCNT_W-1:0] StallCount
);

    id_operands_t          id_ops;
    logic                  lu;
    logic                  mdh;
    logic                  stall;
    logic                  md_busy;
    logic [STALLCNT_W-1:0] stall_cnt_q;

    assign id_ops = {IFID_Rs, IFID_Rt, IFID_UsesRt};
    assign lu     = load_use(IDEX_MemRead, IDEX_Rt, id_ops);
    assign mdh    = md_busy & (IFID_IsHiLoRead | MDStart);
    assign stall  = lu | mdh;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_tracker (
        .Clk      (Clk),
        .Reset    (Reset),
        .MDAccept (MDStart & ~stall),
        .MDBusy   (md_busy)
    );

    // Reset freezes the PC and IF/ID and feeds nops; a stalled branch is dropped and retried
    always_comb begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IFIDFlush  = 1'b1;
        IDEXBubble = 1'b1;
        if (!Reset) begin
            PCWrite    = ~stall;
            IFIDWrite  = ~stall;
            IFIDFlush  = BranchTaken & ~stall;
            IDEXBubble = stall;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != STALLCNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + STALLCNT_W'(1);
        end
    end

    assign MDBusy     = md_busy;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand-written
// multi-cycle sequences and random traffic against a timestamp-based model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned LAT = 4;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       hilo;
        logic       start;
        logic       memrd;
        logic [4:0] xrt;
        logic       br;
    } in_t;

    typedef struct {
        in_t  in;
        logic exp_stall;
        logic exp_flush;
    } tv_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [4:0] IFID_Rs = '0, IFID_Rt = '0, IDEX_Rt = '0;
    logic       IFID_UsesRt = 1'b0, IFID_IsHiLoRead = 1'b0, MDStart = 1'b0;
    logic       IDEX_MemRead = 1'b0, BranchTaken = 1'b0;
    logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy;
    logic [7:0] StallCount;
    logic       pcw1, ifw1, fl1, bub1, MDBusy1;
    logic [7:0] sc1;

    pipeline_hazard_ctrl #(.MD_LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IFID_IsHiLoRead(IFID_IsHiLoRead), .MDStart(MDStart),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXBubble(IDEXBubble), .MDBusy(MDBusy), .StallCount(StallCount)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRt(IFID_UsesRt), .IFID_IsHiLoRead(IFID_IsHiLoRead), .MDStart(MDStart),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .BranchTaken(BranchTaken),
        .PCWrite(pcw1), .IFIDWrite(ifw1), .IFIDFlush(fl1),
        .IDEXBubble(bub1), .MDBusy(MDBusy1), .StallCount(sc1)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int passed = 0;
    // Model: cycle index, first cycle each mult/div unit is free again, expected stall count
    int cyc = 0;
    int free_at = 0;
    int free_at1 = 0;
    int scount = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic in_t mk(input int rs, input int rt, input bit uses, input bit hilo,
                               input bit start, input bit memrd, input int xrt, input bit br);
        in_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses = uses; v.hilo = hilo;
        v.start = start; v.memrd = memrd; v.xrt = 5'(xrt); v.br = br;
        return v;
    endfunction

    // One pipeline cycle: drive at negedge, compare with the model, advance at posedge
    task automatic step(input in_t v, output logic s_stall, output logic s_flush,
                        output logic s_busy, output logic s_busy1);
        bit lu, busy, busy1, stall, stall1;
        @(negedge Clk);
        IFID_Rs = v.rs; IFID_Rt = v.rt; IFID_UsesRt = v.uses; IFID_IsHiLoRead = v.hilo;
        MDStart = v.start; IDEX_MemRead = v.memrd; IDEX_Rt = v.xrt; BranchTaken = v.br;
        #1;
        lu     = v.memrd && (v.xrt != 0) && ((v.xrt == v.rs) || (v.uses && (v.xrt == v.rt)));
        busy   = cyc < free_at;
        busy1  = cyc < free_at1;
        stall  = lu || (busy && (v.hilo || v.start));
        stall1 = lu || (busy1 && (v.hilo || v.start));
        chk("PCWrite", int'(PCWrite), int'(!stall));
        chk("IFIDWrite", int'(IFIDWrite), int'(!stall));
        chk("IDEXBubble", int'(IDEXBubble), int'(stall));
        chk("IFIDFlush", int'(IFIDFlush), int'(v.br && !stall));
        chk("MDBusy", int'(MDBusy), int'(busy));
        chk("StallCount", int'(StallCount), scount);
        chk("MDBusy_lat1", int'(MDBusy1), int'(busy1));
        s_stall = IDEXBubble; s_flush = IFIDFlush; s_busy = MDBusy; s_busy1 = MDBusy1;
        if (v.start && !stall)  free_at  = cyc + 1 + int'(LAT);
        if (v.start && !stall1) free_at1 = cyc + 2;
        if (stall && scount < 255) scount++;
        @(posedge Clk);
        cyc++;
    endtask

    // Asynchronous reset asserted mid-cycle, released just after the next posedge
    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("rst_PCWrite", int'(PCWrite), 0);
        chk("rst_IFIDWrite", int'(IFIDWrite), 0);
        chk("rst_IFIDFlush", int'(IFIDFlush), 1);
        chk("rst_IDEXBubble", int'(IDEXBubble), 1);
        chk("rst_MDBusy", int'(MDBusy), 0);
        chk("rst_MDBusy_lat1", int'(MDBusy1), 0);
        chk("rst_StallCount", int'(StallCount), 0);
        free_at = 0; free_at1 = 0; scount = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        tv_t  tbl[8];
        in_t  idle, lu_v, hilo_v, st_v;
        logic s, f, b, b1;
        int   exp_tbl_cnt;

        idle   = mk(0, 0, 0, 0, 0, 0, 0, 0);
        lu_v   = mk(8, 0, 0, 0, 0, 1, 8, 0);
        hilo_v = mk(0, 0, 0, 1, 0, 0, 0, 0);
        st_v   = mk(0, 0, 0, 0, 1, 0, 0, 0);

        tbl[0] = '{mk(8, 0, 0, 0, 0, 1, 8, 0), 1'b1, 1'b0};
        tbl[1] = '{mk(0, 0, 1, 0, 0, 1, 0, 0), 1'b0, 1'b0};
        tbl[2] = '{mk(3, 8, 1, 0, 0, 1, 8, 0), 1'b1, 1'b0};
        tbl[3] = '{mk(3, 8, 0, 0, 0, 1, 8, 0), 1'b0, 1'b0};
        tbl[4] = '{mk(1, 2, 1, 0, 0, 0, 0, 1), 1'b0, 1'b1};
        tbl[5] = '{mk(9, 2, 1, 0, 0, 1, 9, 1), 1'b1, 1'b0};
        tbl[6] = '{mk(0, 0, 0, 1, 0, 0, 0, 0), 1'b0, 1'b0};
        tbl[7] = '{mk(8, 8, 1, 0, 0, 0, 8, 0), 1'b0, 1'b0};

        // Reset, then idle: pipeline runs freely
        do_reset();
        step(idle, s, f, b, b1);
        chk("idle_stall", int'(s), 0);

        // Single-cycle vectors from an idle mult/div unit
        exp_tbl_cnt = 0;
        foreach (tbl[i]) begin
            step(tbl[i].in, s, f, b, b1);
            chk($sformatf("vec%0d_stall", i), int'(s), int'(tbl[i].exp_stall));
            chk($sformatf("vec%0d_flush", i), int'(f), int'(tbl[i].exp_flush));
            if (tbl[i].exp_stall) exp_tbl_cnt++;
        end
        #1;
        chk("table_stallcount", int'(StallCount), exp_tbl_cnt);

        // mult at cycle 0, mfhi held from cycle 1: four stall cycles
        do_reset();
        step(st_v, s, f, b, b1);
        chk("mul_issue_stall", int'(s), 0);
        for (int i = 1; i <= 4; i++) begin
            step(hilo_v, s, f, b, b1);
            chk($sformatf("mfhi_c%0d_stall", i), int'(s), 1);
            chk($sformatf("mfhi_c%0d_busy", i), int'(b), 1);
            if (i == 1) chk("lat1_busy_c1", int'(b1), 1);
            if (i == 2) chk("lat1_busy_c2", int'(b1), 0);
        end
        step(hilo_v, s, f, b, b1);
        chk("mfhi_c5_stall", int'(s), 0);
        chk("mfhi_c5_busy", int'(b), 0);
        #1;
        chk("mfhi_stallcount", int'(StallCount), 4);

        // Back-to-back mult/div: second issue waits, then reloads the latency
        do_reset();
        step(st_v, s, f, b, b1);
        for (int i = 1; i <= 4; i++) begin
            step(st_v, s, f, b, b1);
            chk($sformatf("b2b_c%0d_stall", i), int'(s), 1);
        end
        step(st_v, s, f, b, b1);
        chk("b2b_accept_stall", int'(s), 0);
        step(idle, s, f, b, b1);
        chk("b2b_reload_busy", int'(b), 1);

        // Saturation: persistent load-use hazard
        do_reset();
        repeat (300) step(lu_v, s, f, b, b1);
        #1;
        chk("sat_300", int'(StallCount), 255);
        repeat (5) step(lu_v, s, f, b, b1);
        #1;
        chk("sat_hold", int'(StallCount), 255);

        // Reset during MD_WAIT clears the unit immediately
        do_reset();
        step(st_v, s, f, b, b1);
        step(idle, s, f, b, b1);
        chk("midrst_busy_before", int'(b), 1);
        do_reset();
        step(hilo_v, s, f, b, b1);
        chk("midrst_mfhi_stall", int'(s), 0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            in_t v;
            v.rs    = 5'($urandom_range(0, 3));
            v.rt    = 5'($urandom_range(0, 3));
            v.uses  = 1'($urandom_range(0, 1));
            v.hilo  = ($urandom_range(0, 3) == 0);
            v.start = ($urandom_range(0, 3) == 0);
            v.memrd = ($urandom_range(0, 2) == 0);
            v.xrt   = 5'($urandom_range(0, 3));
            v.br    = ($urandom_range(0, 2) == 0);
            step(v, s, f, b, b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
